// File: rtl/stack.sv
// LIFO stack with registered pop data and occupancy/almost flags.
// Latency: pop data appears on rd_data one cycle after an accepted pop; push+pop bypasses wr_data in one cycle.
// Backpressure: none; pushes while full and pops while empty are dropped (optionally flagged sticky).
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   wr_req, wr_data     push request and data
//   rd_req, rd_data     pop request and registered pop data (holds when no pop is accepted)
//   count               current occupancy, 0..p_depth
//   full, empty         count == p_depth / count == 0
//   almost_full         count >= p_depth - p_early_flag_thresh
//   almost_empty        count <= p_early_flag_thresh
//   overflow, underflow sticky reject flags, live only when STACK_OVF_CHECK_EN is defined;
//                       tied to 0 otherwise

module stack #(
  parameter int p_width             = 32,
  parameter int p_depth             = 32,
  parameter int p_early_flag_thresh = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             wr_req,
  input  logic [p_width-1:0]               wr_data,
  output logic                             full,
  input  logic                             rd_req,
  output logic [p_width-1:0]               rd_data,
  output logic                             empty,
  output logic                             almost_full,
  output logic                             almost_empty,
  output logic [$clog2(p_depth+1)-1:0]     count,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int CW = $clog2(p_depth + 1);
  localparam int AW = $clog2(p_depth);

  localparam logic [CW-1:0] DEPTH_C = CW'(p_depth);
  localparam logic [CW-1:0] AF_C    = CW'(p_depth - p_early_flag_thresh);
  localparam logic [CW-1:0] AE_C    = CW'(p_early_flag_thresh);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [p_width-1:0] mem [p_depth];

  logic          push_only;
  logic          pop_only;
  logic          bypass;
  logic          do_push;
  logic          do_pop;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign push_only = wr_req & ~rd_req;
  assign pop_only  = rd_req & ~wr_req;
  // Push and pop together never touch memory or count, so it is legal even when full or empty.
  assign bypass    = wr_req & rd_req;
  assign do_push   = push_only & ~full;
  assign do_pop    = pop_only & ~empty;

  // count < p_depth whenever a push is accepted, so its low bits address the free slot.
  assign wr_idx = count[AW-1:0];
  assign rd_idx = AW'(count - ONE_C);

  always_ff @(posedge clock) begin
    if (!reset && do_push) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (bypass) begin
        rd_data <= wr_data;
      end else if (do_pop) begin
        rd_data <= mem[rd_idx];
      end

      if (do_push) begin
        count <= count + ONE_C;
      end else if (do_pop) begin
        count <= count - ONE_C;
      end
    end
  end

  // Flags depend on the count register only, never on the request inputs.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

`ifdef STACK_OVF_CHECK_EN
  logic ovf_q;
  logic udf_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (push_only && full) begin
        ovf_q <= 1'b1;
      end
      if (pop_only && empty) begin
        udf_q <= 1'b1;
      end
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_stack.sv
module tb_stack;

  localparam int W     = 32;
  localparam int DEPTH = 32;
  localparam int THR   = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wr_req = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          rd_req = 1'b0;
  logic          full;
  logic [W-1:0]  rd_data;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [5:0]    count;
  logic          overflow;
  logic          underflow;

  stack #(
    .p_width             (W),
    .p_depth             (DEPTH),
    .p_early_flag_thresh (THR)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .wr_req       (wr_req),
    .wr_data      (wr_data),
    .full         (full),
    .rd_req       (rd_req),
    .rd_data      (rd_data),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: a queue whose back is the top of stack.
  logic [W-1:0] q[$];
  logic [W-1:0] m_rd  = '0;
  logic         m_ovf = 1'b0;
  logic         m_udf = 1'b0;

`ifdef STACK_OVF_CHECK_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      m_rd  = '0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (wr_req && rd_req) begin
      m_rd = wr_data;
    end else if (wr_req) begin
      if (q.size() < DEPTH) q.push_back(wr_data);
      else if (OVF_ON) m_ovf = 1'b1;
    end else if (rd_req) begin
      if (q.size() > 0) m_rd = q.pop_back();
      else if (OVF_ON) m_udf = 1'b1;
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("count",        64'(count),        64'(q.size()));
      chk("rd_data",      64'(rd_data),      64'(m_rd));
      chk("full",         64'(full),         64'(q.size() == DEPTH));
      chk("empty",        64'(empty),        64'(q.size() == 0));
      chk("almost_full",  64'(almost_full),  64'(q.size() >= DEPTH - THR));
      chk("almost_empty", 64'(almost_empty), 64'(q.size() <= THR));
      chk("overflow",     64'(overflow),     64'(m_ovf));
      chk("underflow",    64'(underflow),    64'(m_udf));
    end
  end

  // Apply one cycle of requests from a negedge and return at the next negedge.
  task automatic cyc(input logic w, input logic [W-1:0] d, input logic r);
    wr_req  = w;
    wr_data = d;
    rd_req  = r;
    @(negedge clock);
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset  = 1'b0;
    cmp_en = 1'b1;

    // Idle after reset
    cyc(0, 0, 0);
    chk("lit_rst_count", 64'(count), 0);
    chk("lit_rst_empty", 64'(empty), 1);
    chk("lit_rst_full", 64'(full), 0);
    chk("lit_rst_rd", 64'(rd_data), 0);
    chk("lit_rst_ae", 64'(almost_empty), 1);

    // Fill 0..31
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, W'(i), 0);
      chk("lit_fill_count", 64'(count), 64'(i + 1));
      chk("lit_fill_af", 64'(almost_full), 64'((i + 1) >= 28));
    end
    chk("lit_full", 64'(full), 1);
    cyc(1, 32'd99, 0);
    chk("lit_ovf_count", 64'(count), 32);
    chk("lit_ovf_flag", 64'(overflow), 64'(OVF_ON));

    // Drain: 31 down to 0
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 0, 1);
      chk("lit_drain_rd", 64'(rd_data), 64'(31 - i));
    end
    chk("lit_drain_empty", 64'(empty), 1);
    cyc(0, 0, 1);
    chk("lit_udf_rd", 64'(rd_data), 0);
    chk("lit_udf_flag", 64'(underflow), 64'(OVF_ON));

    // Bypass in the middle of the stack
    cyc(1, 32'd5, 0);
    cyc(1, 32'd6, 0);
    cyc(1, 32'd7, 0);
    cyc(1, 32'd100, 1);
    chk("lit_byp_rd", 64'(rd_data), 100);
    chk("lit_byp_count", 64'(count), 3);
    cyc(0, 0, 1);
    chk("lit_byp_next", 64'(rd_data), 7);
    cyc(0, 0, 1);
    chk("lit_pop6", 64'(rd_data), 6);
    cyc(0, 0, 1);
    chk("lit_pop5", 64'(rd_data), 5);

    // Bypass while full and while empty
    for (int i = 0; i < DEPTH; i++) cyc(1, W'(200 + i), 0);
    cyc(1, 32'hAA, 1);
    chk("lit_fullbyp_rd", 64'(rd_data), 64'h AA);
    chk("lit_fullbyp_full", 64'(full), 1);
    cyc(0, 0, 1);
    chk("lit_fullbyp_top", 64'(rd_data), 231);
    for (int i = 0; i < DEPTH - 1; i++) cyc(0, 0, 1);
    chk("lit_last_rd", 64'(rd_data), 200);
    cyc(1, 32'hAA, 1);
    chk("lit_emptybyp_rd", 64'(rd_data), 64'h AA);
    chk("lit_emptybyp_empty", 64'(empty), 1);

    // Reset mid-operation with a request active in the same cycle
    for (int i = 0; i < 10; i++) cyc(1, W'(300 + i), 0);
    chk("lit_pre_rst_count", 64'(count), 10);
    reset = 1'b1;
    cyc(1, 32'h77, 0);
    reset = 1'b0;
    chk("lit_mid_rst_count", 64'(count), 0);
    chk("lit_mid_rst_empty", 64'(empty), 1);
    chk("lit_mid_rst_ovf", 64'(overflow), 0);
    cyc(1, 32'h55, 0);
    cyc(0, 0, 1);
    chk("lit_post_rst_rd", 64'(rd_data), 64'h55);
    chk("lit_post_rst_empty", 64'(empty), 1);

    // Randomized traffic with push-heavy and pop-heavy phases
    for (int i = 0; i < 4000; i++) begin
      int unsigned roll;
      bit push_bias;
      push_bias = ((i / 150) % 2) == 0;
      roll = $urandom_range(99);
      reset = ($urandom_range(299) == 0);
      if (roll < 15) cyc(1, $urandom, 1);
      else if (roll < 25) cyc(0, 0, 0);
      else if (push_bias ? (roll < 80) : (roll < 45)) cyc(1, $urandom, 0);
      else cyc(0, 0, 1);
      reset = 1'b0;
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
